// File: rtl/adc_sample_reader.sv
// SPI-style ADC sampler: one trigger runs one 16-bit command/response frame.
// The 12-bit result is taken from the last 12 bits shifted in.
module adc_sample_reader #(
    parameter int unsigned SCLK_DIV = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_trigger,
    input  logic [2:0]  channel,
    input  logic        clear_overrun,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic [11:0] sample_data,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned DATA_W  = 12;
    localparam int unsigned RX_W    = DATA_W - 1;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned CNT_W   = $clog2(2 * SCLK_DIV);

    localparam logic [CNT_W-1:0] HALF_END   = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(2 * SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [FRAME_W-1:0]   cmd_q, cmd_d;
    logic [RX_W-1:0]      rx_q, rx_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 din_q, din_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            cmd_q     <= '0;
            rx_q      <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            din_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            cmd_q     <= cmd_d;
            rx_q      <= rx_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        cmd_d     = cmd_q;
        rx_d      = rx_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        din_d     = din_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        // Set has priority over clear; busy_q is still high on the completing edge
        if (sample_trigger && busy_q) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (sample_trigger) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    cmd_d   = {2'b00, channel, 11'b0};
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            SETUP: begin
                if (cnt_q == HALF_END) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    din_d   = cmd_q[FRAME_W-1];
                    cmd_d   = {cmd_q[FRAME_W-2:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SHIFT: begin
                if (cnt_q == HALF_END) begin
                    sclk_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end else if (cnt_q == PERIOD_END) begin
                    // End of a high phase: sample, then either fall or finish
                    rx_d  = {rx_q[RX_W-2:0], adc_dout};
                    cnt_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = IDLE;
                        cs_n_d  = 1'b1;
                        sclk_d  = 1'b1;
                        din_d   = 1'b0;
                        busy_d  = 1'b0;
                        data_d  = {rx_q, adc_dout};
                        valid_d = 1'b1;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b0;
                        din_d  = cmd_q[FRAME_W-1];
                        cmd_d  = {cmd_q[FRAME_W-2:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
                din_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign adc_din      = din_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/adc_sample_reader.md
ADC_SAMPLE_READER -- requirements
Module: adc_sample_reader

Interface
REQ-001 Parameter SCLK_DIV, default 8: clk cycles per adc_sclk half-period; legal range >= 2.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 sample_trigger  input  1  one-cycle pulse requesting one conversion frame.
REQ-005 channel  input  3  ADC input channel to convert, captured at the accepted trigger.
REQ-006 clear_overrun  input  1  synchronous clear of overrun.
REQ-007 adc_cs_n  output  1  ADC chip select, active low.
REQ-008 adc_sclk  output  1  ADC serial clock, idle high.
REQ-009 adc_din  output  1  serial command to the ADC, MSB first.
REQ-010 adc_dout  input  1  serial data from the ADC, MSB first.
REQ-011 sample_data  output  12  last completed conversion result.
REQ-012 sample_valid  output  1  one-cycle pulse when sample_data updates.
REQ-013 busy  output  1  high while a frame is in progress.
REQ-014 overrun  output  1  sticky flag: a trigger arrived while busy.

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP and SHIFT, with all outputs registered.
REQ-016 In IDLE, a clk edge sampling sample_trigger=1 (edge E0) SHALL latch channel, drive adc_cs_n=0 and busy=1, and enter SETUP.
REQ-017 SETUP SHALL last SCLK_DIV cycles with adc_sclk=1; at the ending edge, adc_sclk<=0, adc_din<=frame bit 15, and the FSM enters SHIFT.
REQ-018 The command frame SHALL be the 16 bits {2'b00, latched channel[2:0], 11'b0}, sent bit 15 first.
REQ-019 SHIFT SHALL generate exactly 16 adc_sclk periods; each period is SCLK_DIV cycles low, then SCLK_DIV cycles high.
REQ-020 adc_din SHALL change only on edges that drive adc_sclk low, presenting the next frame bit each time.
REQ-021 adc_dout SHALL be sampled at each edge that ends a high phase (16 samples) and shifted in, MSB first.
REQ-022 At the edge ending the 16th high phase (E0 + 33*SCLK_DIV), the block SHALL set adc_cs_n=1, adc_sclk=1, adc_din=0 and busy=0.
REQ-023 At that same edge, sample_data SHALL be set to the last 12 received bits and sample_valid set to 1 for exactly one cycle.
REQ-024 Trigger-to-valid latency SHALL be exactly 33*SCLK_DIV cycles (264 at the default).
REQ-025 adc_cs_n SHALL be low for exactly 33*SCLK_DIV cycles per frame.
REQ-026 A trigger sampled while busy=1, including at the completing edge, SHALL be ignored and SHALL set overrun=1.
REQ-027 Changes to channel after E0 SHALL NOT affect the frame in progress.
REQ-028 clear_overrun SHALL clear overrun on the next edge; if a set and a clear occur on the same edge, the set SHALL win.
REQ-029 A trigger arriving on the first cycle after completion SHALL be accepted, so frames run back to back without a gap.
REQ-030 sample_data SHALL hold its value between sample_valid pulses.
REQ-031 Internal counters SHALL be sized for 2*SCLK_DIV and SHALL NOT wrap within a frame.

Reset
REQ-032 When reset_n=0, the block SHALL immediately set adc_cs_n=1, adc_sclk=1, adc_din=0, sample_data=0, sample_valid=0, busy=0, overrun=0, and the FSM to IDLE.
REQ-033 A reset during a frame SHALL abort the frame without a sample_valid pulse; the first trigger after release SHALL start a complete new frame.

Verification
REQ-034 The bench SHALL cover: trigger with channel=5, ADC model returning 0x0ABC -> adc_din frame 0x2800, 16 adc_sclk falling edges, sample_valid 264 cycles after the trigger, sample_data=0xABC.
REQ-035 The bench SHALL cover: channel changed from 5 to 2 at E0+10 -> frame remains 0x2800.
REQ-036 The bench SHALL cover: second trigger at E0+100 -> ignored, overrun=1, a single sample_valid; clear_overrun then gives overrun=0 on the next cycle.
REQ-037 The bench SHALL cover: triggers at the completing edge and one cycle later -> the first sets overrun, the second starts a new frame with adc_cs_n low again.
REQ-038 The bench SHALL cover: reset_n pulsed low at E0+150 -> adc_cs_n=1 immediately, no sample_valid, sample_data=0.
REQ-039 The bench SHALL cover: a free-running 401-cycle trigger with ADC pattern 0xFFF then 0x000 -> a valid pulse every 401 cycles, correct data, overrun stays 0.
